as1802_uart: RTL and testbench
==============================

AS1802_UART -- requirements
Module: as1802_uart

Interface
REQ-001 Parameters: none; bit timing is set at run time by the divisor port only.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 divisor  input  16  clocks per bit; values 0 and 1 are treated as 2.
REQ-005 din  input  8  TX byte, sampled in the cycle start is accepted.
REQ-006 start  input  1  one-cycle TX request pulse.
REQ-007 busy  output  1  high while a TX frame is in progress.
REQ-008 TX  output  1  serial out, idles high.
REQ-009 RX  input  1  serial in, asynchronous to clk.
REQ-010 dout  output  8  last byte received.
REQ-011 has_byte  output  1  set when a valid byte lands in dout.
REQ-012 clr_hb  input  1  one-cycle pulse that clears has_byte.

Function
REQ-013 Frame format: 8N1 = start bit 0, 8 data bits LSB first, stop bit 1; every bit lasts exactly D clocks, where D = max(divisor, 2).
REQ-014 TX FSM states: IDLE, START, DATA, STOP.
REQ-015 TX from IDLE: start=1 latches din into the shift register and enters START; on the next cycle busy=1 and TX=0.
REQ-016 start while busy=1 is ignored; no queueing.
REQ-017 TX after START (D clocks): enters DATA, which shifts out 8 bits of D clocks each; then STOP drives TX=1 for D clocks; then IDLE with busy=0. Total busy time is 10*D clocks.
REQ-018 A new start is accepted in the first cycle that busy=0, so back-to-back frames have no extra idle time.
REQ-019 The TX bit counter is a 16-bit down-counter reloaded with D-1 at each bit boundary; divisor is sampled at each reload, so a mid-frame change takes effect from the next bit.
REQ-020 RX FSM states: IDLE, START, DATA, STOP.
REQ-021 RX IDLE: a falling edge on the sampled RX (previous 1, current 0) enters START and loads the counter with (D>>1)-1.
REQ-022 RX START: at counter expiry, sampled RX=1 is a glitch and returns to IDLE; sampled RX=0 enters DATA with the counter reloaded to D-1.
REQ-023 RX DATA: samples 8 bits, one every D clocks at mid-bit, shifting in LSB first, then enters STOP.
REQ-024 RX STOP, sample=1: dout is loaded and has_byte=1 on the next cycle, then IDLE.
REQ-025 RX STOP, sample=0 (framing error): the byte is discarded, dout and has_byte are unchanged, and the FSM waits in STOP until RX is sampled high before returning to IDLE.
REQ-026 Overrun: a new valid byte overwrites dout regardless of has_byte.
REQ-027 clr_hb=1 clears has_byte on the next cycle.
REQ-028 If clr_hb and byte completion occur in the same cycle, the set wins and has_byte=1.
REQ-029 The TX and RX paths are fully independent; simultaneous activity is allowed.

Reset
REQ-030 While rst=1, asynchronously: TX=1, busy=0, dout=0x00, has_byte=0, both FSMs in IDLE, counters=0, sampled RX history=1.
REQ-031 Reset mid-frame aborts the frame immediately; TX returns high with no partial stop bit.
REQ-032 After rst falls, the first rising edge may accept start.

Configuration
REQ-033 Macro UART_RX_SYNC_EN defined: RX passes through a 2-flop synchronizer before edge detection, adding 2 clocks of RX latency; has_byte then rises at stop mid-bit +3 clocks.
REQ-034 UART_RX_SYNC_EN undefined: RX is registered once, and has_byte rises at stop mid-bit +1 clock.
REQ-035 With or without the macro, all other timing is identical.

Verification
REQ-036 divisor=10, din=0x55, start pulse -> busy high for 100 clocks; TX pattern 0,1,0,1,0,1,0,1,0,1, each bit 10 clocks.
REQ-037 TX looped to RX, divisor=4, send 0xA3 -> dout=0xA3, has_byte=1; clr_hb pulse -> has_byte=0 next cycle.
REQ-038 divisor=10, RX low pulse of 3 clocks -> glitch rejected; has_byte stays 0 and RX FSM returns to IDLE.
REQ-039 divisor=8, RX frame 0x3C with stop bit 0 -> dout unchanged, has_byte=0; RX FSM stays in STOP until RX returns high.
REQ-040 Two bytes 0x11 then 0x22 with no clr_hb -> dout=0x22, has_byte=1; clr_hb coinciding with completion of the second byte -> has_byte=1.
REQ-041 rst asserted 35 clocks into a divisor=10 frame -> TX=1, busy=0 immediately; a new start after release sends a full frame.

Source files
------------

// File: rtl/as1802_uart.sv
// as1802_uart: 8N1 UART transmitter and receiver, bit time set by divisor.
// Define UART_RX_SYNC_EN to put a 2-flop synchronizer on RX.
module as1802_uart (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] divisor,
  input  logic [7:0]  din,
  input  logic        start,
  output logic        busy,
  output logic        TX,
  input  logic        RX,
  output logic [7:0]  dout,
  output logic        has_byte,
  input  logic        clr_hb
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic [15:0] d_eff;
  logic [15:0] d_m1;
  logic [15:0] d_half_m1;

  assign d_eff     = (divisor < 16'd2) ? 16'd2 : divisor;
  assign d_m1      = d_eff - 16'd1;
  assign d_half_m1 = (d_eff >> 1) - 16'd1;

  state_t      tx_st, tx_st_n;
  logic [15:0] tx_cnt, tx_cnt_n;
  logic [7:0]  tx_sh, tx_sh_n;
  logic [2:0]  tx_bit, tx_bit_n;

  // TX state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_st  <= IDLE;
      tx_cnt <= '0;
      tx_sh  <= '0;
      tx_bit <= '0;
    end else begin
      tx_st  <= tx_st_n;
      tx_cnt <= tx_cnt_n;
      tx_sh  <= tx_sh_n;
      tx_bit <= tx_bit_n;
    end
  end

  // TX next state: count D clocks per bit, reload at each boundary
  always_comb begin
    tx_st_n  = tx_st;
    tx_cnt_n = tx_cnt;
    tx_sh_n  = tx_sh;
    tx_bit_n = tx_bit;
    unique case (tx_st)
      IDLE: begin
        if (start) begin
          tx_sh_n  = din;
          tx_cnt_n = d_m1;
          tx_bit_n = '0;
          tx_st_n  = START;
        end
      end
      START: begin
        if (tx_cnt == 16'd0) begin
          tx_cnt_n = d_m1;
          tx_st_n  = DATA;
        end else begin
          tx_cnt_n = tx_cnt - 16'd1;
        end
      end
      DATA: begin
        if (tx_cnt == 16'd0) begin
          tx_cnt_n = d_m1;
          tx_sh_n  = {1'b0, tx_sh[7:1]};
          tx_bit_n = tx_bit + 3'd1;
          if (tx_bit == 3'd7)
            tx_st_n = STOP;
        end else begin
          tx_cnt_n = tx_cnt - 16'd1;
        end
      end
      STOP: begin
        if (tx_cnt == 16'd0)
          tx_st_n = IDLE;
        else
          tx_cnt_n = tx_cnt - 16'd1;
      end
    endcase
  end

  // TX line and busy decode straight from state, so reset forces idle at once
  always_comb begin
    busy = (tx_st != IDLE);
    TX   = 1'b1;
    unique case (tx_st)
      IDLE:  TX = 1'b1;
      START: TX = 1'b0;
      DATA:  TX = tx_sh[0];
      STOP:  TX = 1'b1;
    endcase
  end

  logic rx_s;
  logic rx_prev;

`ifdef UART_RX_SYNC_EN
  logic rx_m1;
  logic rx_m2;

  // RX synchronizer, sample register and edge history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m1   <= 1'b1;
      rx_m2   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_m1   <= RX;
      rx_m2   <= rx_m1;
      rx_s    <= rx_m2;
      rx_prev <= rx_s;
    end
  end
`else
  // RX sample register and edge history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s    <= RX;
      rx_prev <= rx_s;
    end
  end
`endif

  state_t      rx_st, rx_st_n;
  logic [15:0] rx_cnt, rx_cnt_n;
  logic [7:0]  rx_sh, rx_sh_n;
  logic [2:0]  rx_bit, rx_bit_n;
  logic        rx_err, rx_err_n;
  logic        rx_done;

  // RX state register plus received byte and its flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_st    <= IDLE;
      rx_cnt   <= '0;
      rx_sh    <= '0;
      rx_bit   <= '0;
      rx_err   <= 1'b0;
      dout     <= '0;
      has_byte <= 1'b0;
    end else begin
      rx_st  <= rx_st_n;
      rx_cnt <= rx_cnt_n;
      rx_sh  <= rx_sh_n;
      rx_bit <= rx_bit_n;
      rx_err <= rx_err_n;
      if (rx_done) begin
        dout     <= rx_sh;
        has_byte <= 1'b1;
      end else if (clr_hb) begin
        has_byte <= 1'b0;
      end
    end
  end

  // RX next state: half-bit to centre, then sample every D clocks
  always_comb begin
    rx_st_n  = rx_st;
    rx_cnt_n = rx_cnt;
    rx_sh_n  = rx_sh;
    rx_bit_n = rx_bit;
    rx_err_n = rx_err;
    rx_done  = 1'b0;
    unique case (rx_st)
      IDLE: begin
        if (rx_prev && !rx_s) begin
          rx_cnt_n = d_half_m1;
          rx_err_n = 1'b0;
          rx_st_n  = START;
        end
      end
      START: begin
        if (rx_cnt != 16'd0) begin
          rx_cnt_n = rx_cnt - 16'd1;
        end else if (rx_s) begin
          rx_st_n = IDLE;
        end else begin
          rx_cnt_n = d_m1;
          rx_bit_n = '0;
          rx_st_n  = DATA;
        end
      end
      DATA: begin
        if (rx_cnt != 16'd0) begin
          rx_cnt_n = rx_cnt - 16'd1;
        end else begin
          rx_sh_n  = {rx_s, rx_sh[7:1]};
          rx_cnt_n = d_m1;
          rx_bit_n = rx_bit + 3'd1;
          if (rx_bit == 3'd7)
            rx_st_n = STOP;
        end
      end
      STOP: begin
        if (rx_cnt != 16'd0) begin
          rx_cnt_n = rx_cnt - 16'd1;
        end else if (rx_s) begin
          rx_done  = !rx_err;
          rx_err_n = 1'b0;
          rx_st_n  = IDLE;
        end else begin
          rx_err_n = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_as1802_uart.sv
// tb_as1802_uart: scoreboard bench for as1802_uart.
// Loopback plus directed RX frames, decoded by an abstract line model.
module tb_as1802_uart;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] divisor;
  logic [7:0]  din;
  logic        start;
  logic        busy;
  logic        tx;
  logic        rx;
  logic [7:0]  dout;
  logic        has_byte;
  logic        clr_hb;

  logic loop;
  logic rx_drv;
  logic clr_mon;
  logic clr_stim;

  assign rx     = loop ? tx : rx_drv;
  assign clr_hb = clr_mon | clr_stim;

`ifdef UART_RX_SYNC_EN
  localparam int RX_LAT = 2;
`else
  localparam int RX_LAT = 0;
`endif

  as1802_uart dut (
    .clk      (clk),
    .rst      (rst),
    .divisor  (divisor),
    .din      (din),
    .start    (start),
    .busy     (busy),
    .TX       (tx),
    .RX       (rx),
    .dout     (dout),
    .has_byte (has_byte),
    .clr_hb   (clr_hb)
  );

  always #5 clk = ~clk;

  int          compared   = 0;
  int          mismatched = 0;
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  int          cur_d      = 2;
  bit          tx_mon_en  = 1'b1;
  bit          rx_mon_en  = 1'b1;
  logic [7:0]  last_rx    = 8'h00;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int eff(input int dv);
    return (dv < 2) ? 2 : dv;
  endfunction

  // line-level decoder of TX: find start, sample each bit at its centre
  initial begin : tx_mon
    int         d;
    logic [7:0] b;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (tx_mon_en && tx === 1'b0) begin
        d = cur_d;
        b = 8'h00;
        repeat (d / 2) @(negedge clk);
        check("tx_start_bit", 32'(tx), 32'h0);
        for (int i = 0; i < 8; i++) begin
          repeat (d) @(negedge clk);
          b[i] = tx;
        end
        repeat (d) @(negedge clk);
        check("tx_stop_bit", 32'(tx), 32'h1);
        if (tx_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL tx_unexpected: got byte %02h, none pending", b);
        end else begin
          e = tx_q.pop_front();
          check("tx_byte", 32'(b), 32'(e));
        end
      end
    end
  end

  // RX scoreboard: on each has_byte rise compare dout, then clear it
  initial begin : rx_mon
    logic       hb_q;
    logic [7:0] e;
    hb_q    = 1'b0;
    clr_mon = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_mon_en && has_byte === 1'b1 && !hb_q) begin
        if (rx_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL rx_unexpected: got byte %02h, none pending", dout);
        end else begin
          e = rx_q.pop_front();
          check("rx_byte", 32'(dout), 32'(e));
          last_rx = e;
        end
        clr_mon = 1'b1;
        @(negedge clk);
        clr_mon = 1'b0;
        check("rx_clr_hb", 32'(has_byte), 32'h0);
      end
      hb_q = has_byte;
    end
  end

  // one TX frame from a negedge with busy low; returns at first idle negedge
  task automatic send_tx(input logic [15:0] dv,
                         input logic [7:0] b,
                         input bit push_rx);
    int d;
    int n;
    d       = eff(int'(dv));
    n       = 0;
    divisor = dv;
    cur_d   = d;
    din     = b;
    start   = 1'b1;
    tx_q.push_back(b);
    if (push_rx)
      rx_q.push_back(b);
    @(negedge clk);
    start = 1'b0;
    din   = 8'($urandom);
    while (busy === 1'b1 && n < 20 * d) begin
      n++;
      start = (n == 3);
      @(negedge clk);
    end
    start = 1'b0;
    check("tx_busy_len", 32'(n), 32'(10 * d));
  endtask

  // bench-driven RX frame, one bit every d clocks
  task automatic drive_rx(input logic [7:0] b,
                          input logic stop,
                          input int d);
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (d) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (d) @(negedge clk);
    end
    rx_drv = stop;
    repeat (d) @(negedge clk);
  endtask

  initial begin : stim
    logic [15:0] dv;
    logic [7:0]  b;
    rst      = 1'b1;
    divisor  = 16'd2;
    din      = 8'h00;
    start    = 1'b0;
    loop     = 1'b1;
    rx_drv   = 1'b1;
    clr_stim = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_has_byte", 32'(has_byte), 32'h0);
    rst = 1'b0;

    send_tx(16'd10, 8'h55, 1'b1);
    send_tx(16'd4, 8'hA3, 1'b1);
    for (int k = 0; k < 25; k++) begin
      dv = 16'($urandom_range(0, 12));
      b  = 8'($urandom);
      send_tx(dv, b, 1'b1);
    end
    repeat (40) @(negedge clk);

    loop    = 1'b0;
    divisor = 16'd10;
    cur_d   = 10;
    rx_drv  = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_has_byte", 32'(has_byte), 32'h0);
    check("glitch_dout", 32'(dout), 32'(last_rx));
    rx_q.push_back(8'hC4);
    drive_rx(8'hC4, 1'b1, 10);
    repeat (20) @(negedge clk);

    divisor = 16'd8;
    cur_d   = 8;
    drive_rx(8'h3C, 1'b0, 8);
    repeat (30) @(negedge clk);
    check("ferr_has_byte", 32'(has_byte), 32'h0);
    check("ferr_dout", 32'(dout), 32'(last_rx));
    rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    check("ferr_has_byte2", 32'(has_byte), 32'h0);
    check("ferr_dout2", 32'(dout), 32'(last_rx));
    rx_q.push_back(8'h96);
    drive_rx(8'h96, 1'b1, 8);
    repeat (20) @(negedge clk);

    rx_mon_en = 1'b0;
    drive_rx(8'h11, 1'b1, 8);
    repeat (20) @(negedge clk);
    check("ovr_first_dout", 32'(dout), 32'h11);
    check("ovr_first_hb", 32'(has_byte), 32'h1);
    fork
      drive_rx(8'h22, 1'b1, 8);
      begin
        @(negedge clk);
        repeat ((8 >> 1) + 1 + 9 * 8 + RX_LAT) @(negedge clk);
        clr_stim = 1'b1;
        @(negedge clk);
        clr_stim = 1'b0;
      end
    join
    check("ovr_second_dout", 32'(dout), 32'h22);
    check("ovr_set_wins_hb", 32'(has_byte), 32'h1);
    clr_stim = 1'b1;
    @(negedge clk);
    clr_stim = 1'b0;
    check("ovr_clr_hb", 32'(has_byte), 32'h0);
    repeat (5) @(negedge clk);
    rx_mon_en = 1'b1;

    loop      = 1'b1;
    tx_mon_en = 1'b0;
    divisor   = 16'd10;
    cur_d     = 10;
    din       = 8'hE7;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (34) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_tx", 32'(tx), 32'h1);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_dout", 32'(dout), 32'h0);
    check("abort_has_byte", 32'(has_byte), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst       = 1'b0;
    tx_mon_en = 1'b1;
    send_tx(16'd10, 8'h3D, 1'b1);
    repeat (40) @(negedge clk);

    check("tx_q_drained", 32'(tx_q.size()), 32'h0);
    check("rx_q_drained", 32'(rx_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
